// File: rtl/int_dispatch.sv
// int_dispatch: interrupt dispatch sequencer. Pushes the return PC onto the stack
// through a held write handshake, then loads the interrupt vector into PC.
module int_dispatch #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clockgb,
    input  logic        reset,
    input  logic        intreq,
    input  logic [15:0] intaddress,
    output logic        intack,
    input  logic        instr_boundary,
    input  logic        ei_exec,
    input  logic        di_exec,
    input  logic        reti_exec,
    input  logic        halt_exec,
    input  logic [15:0] pc,
    input  logic [15:0] sp,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_store,
    input  logic        bus_ack,
    output logic [15:0] pc_new,
    output logic        pc_load,
    output logic [15:0] sp_new,
    output logic        sp_load,
    output logic        cpu_hold,
    output logic        ime,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PUSH_HI,
        S_PUSH_LO,
        S_JUMP
    } state_t;

    localparam logic [1:0] LAST_WAIT = 2'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_waitCnt;
    logic [15:0] r_pcLat;
    logic [15:0] r_spLat;
    logic [15:0] r_busAddr;
    logic [7:0]  r_busWdata;
    logic        r_busStore;
    logic        r_jumpLoad;
    logic [15:0] r_spNew;
    logic        r_ime;
    logic        r_eiDelay;
    logic        r_halted;

    logic        w_take;
    logic        w_inJump;

    // A halted CPU wakes on any request, so halted stands in for the boundary.
    assign w_take   = (instr_boundary || r_halted) && r_ime && intreq && !di_exec;
    assign w_inJump = (r_state == S_JUMP) && !reset;

    // The vector choice is made on intreq as seen in JUMP, so a request withdrawn
    // during the pushes jumps to 0x0000 without acknowledging anything.
    assign intack    = w_inJump && intreq;
    assign pc_new    = (w_inJump && intreq) ? intaddress : 16'h0000;
    assign pc_load   = r_jumpLoad;
    assign sp_load   = r_jumpLoad;
    assign sp_new    = r_spNew;
    assign bus_addr  = r_busAddr;
    assign bus_wdata = r_busWdata;
    assign bus_store = r_busStore;
    assign cpu_hold  = (r_state != S_IDLE) || r_halted;
    assign ime       = r_ime;
    assign halted    = r_halted;

    always_ff @(posedge clockgb) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_waitCnt  <= 2'd0;
            r_pcLat    <= 16'h0000;
            r_spLat    <= 16'h0000;
            r_busAddr  <= 16'h0000;
            r_busWdata <= 8'h00;
            r_busStore <= 1'b0;
            r_jumpLoad <= 1'b0;
            r_spNew    <= 16'h0000;
            r_ime      <= 1'b0;
            r_eiDelay  <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_jumpLoad <= 1'b0;
            if (di_exec) begin
                r_ime     <= 1'b0;
                r_eiDelay <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!di_exec) begin
                        if (instr_boundary && r_eiDelay) begin
                            r_ime     <= 1'b1;
                            r_eiDelay <= 1'b0;
                        end
                        if (ei_exec) begin
                            r_eiDelay <= 1'b1;
                        end
                        if (reti_exec) begin
                            r_ime <= 1'b1;
                        end
                    end
                    if (halt_exec) begin
                        r_halted <= 1'b1;
                    end
                    if (r_halted && intreq) begin
                        r_halted <= 1'b0;
                    end
                    if (w_take) begin
                        r_ime     <= 1'b0;
                        r_halted  <= 1'b0;
                        r_pcLat   <= pc;
                        r_spLat   <= sp;
                        r_waitCnt <= 2'd0;
                        if (WAIT_CYCLES == 0) begin
                            r_state    <= S_PUSH_HI;
                            r_busAddr  <= sp - 16'd1;
                            r_busWdata <= pc[15:8];
                            r_busStore <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_waitCnt == LAST_WAIT) begin
                        r_state    <= S_PUSH_HI;
                        r_busAddr  <= r_spLat - 16'd1;
                        r_busWdata <= r_pcLat[15:8];
                        r_busStore <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + 2'd1;
                    end
                end
                S_PUSH_HI: begin
                    if (bus_ack) begin
                        r_state    <= S_PUSH_LO;
                        r_busAddr  <= r_spLat - 16'd2;
                        r_busWdata <= r_pcLat[7:0];
                    end
                end
                S_PUSH_LO: begin
                    if (bus_ack) begin
                        r_state    <= S_JUMP;
                        r_busStore <= 1'b0;
                        r_jumpLoad <= 1'b1;
                        r_spNew    <= r_spLat - 16'd2;
                    end
                end
                S_JUMP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_dispatch.sv
// tb_int_dispatch: randomized bench; stimulus queues the expected stack writes and
// jump, and a negedge monitor compares them whenever the DUT presents them.
module tb_int_dispatch;

    localparam int WAIT_CYCLES = 2;

    logic        clockgb = 1'b0;
    logic        reset = 1'b1;
    logic        intreq = 1'b0;
    logic [15:0] intaddress = 16'h0000;
    logic        intack;
    logic        instr_boundary = 1'b0;
    logic        ei_exec = 1'b0;
    logic        di_exec = 1'b0;
    logic        reti_exec = 1'b0;
    logic        halt_exec = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] sp = 16'h0000;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_store;
    logic        bus_ack = 1'b0;
    logic [15:0] pc_new;
    logic        pc_load;
    logic [15:0] sp_new;
    logic        sp_load;
    logic        cpu_hold;
    logic        ime;
    logic        halted;

    int_dispatch #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clockgb(clockgb), .reset(reset), .intreq(intreq), .intaddress(intaddress),
        .intack(intack), .instr_boundary(instr_boundary), .ei_exec(ei_exec),
        .di_exec(di_exec), .reti_exec(reti_exec), .halt_exec(halt_exec),
        .pc(pc), .sp(sp), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_store(bus_store), .bus_ack(bus_ack), .pc_new(pc_new), .pc_load(pc_load),
        .sp_new(sp_new), .sp_load(sp_load), .cpu_hold(cpu_hold), .ime(ime),
        .halted(halted)
    );

    always #5 clockgb = ~clockgb;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } write_t;

    typedef struct packed {
        logic [15:0] pcNew;
        logic [15:0] spNew;
        logic        ack;
    } jump_t;

    write_t expWrites[$];
    jump_t  expJumps[$];
    write_t gotWrite;
    jump_t  gotJump;
    int     testsRun = 0;
    int     testsFailed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clockgb);
        #1;
    endtask

    task automatic applyStimulus(input logic ib, input logic ei, input logic di,
                                 input logic reti, input logic halt);
        instr_boundary = ib;
        ei_exec        = ei;
        di_exec        = di;
        reti_exec      = reti;
        halt_exec      = halt;
        tick();
        instr_boundary = 1'b0;
        ei_exec        = 1'b0;
        di_exec        = 1'b0;
        reti_exec      = 1'b0;
        halt_exec      = 1'b0;
    endtask

    // Expected stack image and jump come straight from the latched pc/sp; the
    // ack responder holds off each push by the requested number of cycles.
    task automatic runDispatch(input logic [15:0] pcVal, input logic [15:0] spVal,
                               input logic [15:0] vec, input int d1, input int d2,
                               input bit cancel, input bit viaHalt);
        int delays[2];
        int holdCycles = 0;
        int pushIdx = 0;
        int waitCnt = 0;
        bit seenHold = 1'b0;
        bit done = 1'b0;
        delays[0] = d1;
        delays[1] = d2;
        expWrites.push_back('{addr: spVal - 16'd1, data: pcVal[15:8]});
        expWrites.push_back('{addr: spVal - 16'd2, data: pcVal[7:0]});
        expJumps.push_back('{pcNew: (cancel ? 16'h0000 : vec), spNew: spVal - 16'd2,
                             ack: !cancel});
        pc             = pcVal;
        sp             = spVal;
        intaddress     = vec;
        intreq         = 1'b1;
        instr_boundary = !viaHalt;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            instr_boundary = 1'b0;
            pc             = 16'($urandom);
            sp             = 16'($urandom);
            bus_ack        = 1'b0;
            if (cpu_hold) begin
                seenHold = 1'b1;
                holdCycles++;
            end else if (seenHold) begin
                done = 1'b1;
            end
            if (!done && bus_store && pushIdx < 2) begin
                if (cancel && pushIdx == 1) intreq = 1'b0;
                if (waitCnt == delays[pushIdx]) begin
                    bus_ack = 1'b1;
                    waitCnt = 0;
                    pushIdx++;
                end else begin
                    waitCnt++;
                end
            end
        end
        bus_ack = 1'b0;
        intreq  = 1'b0;
        checkOutput("dispatch_finished", 32'(done), 32'd1);
        checkOutput("hold_cycles", holdCycles, WAIT_CYCLES + d1 + d2 + 3);
        checkOutput("ime_after_dispatch", 32'(ime), 32'd0);
        tick();
    endtask

    logic        prevWaiting = 1'b0;
    logic [15:0] prevAddr = 16'h0000;
    logic [7:0]  prevData = 8'h00;

    always @(negedge clockgb) begin
        if (reset) begin
            prevWaiting = 1'b0;
        end else begin
            if (bus_store && prevWaiting) begin
                checkOutput("held_addr", 32'(bus_addr), 32'(prevAddr));
                checkOutput("held_data", 32'(bus_wdata), 32'(prevData));
            end
            if (bus_store && bus_ack) begin
                checkOutput("write_expected", 32'(expWrites.size() > 0), 32'd1);
                if (expWrites.size() > 0) begin
                    gotWrite = expWrites.pop_front();
                    checkOutput("write_addr", 32'(bus_addr), 32'(gotWrite.addr));
                    checkOutput("write_data", 32'(bus_wdata), 32'(gotWrite.data));
                end
            end
            if (pc_load || sp_load) begin
                checkOutput("load_pair", 32'(sp_load), 32'(pc_load));
                checkOutput("jump_expected", 32'(expJumps.size() > 0), 32'd1);
                if (expJumps.size() > 0) begin
                    gotJump = expJumps.pop_front();
                    checkOutput("jump_pc_new", 32'(pc_new), 32'(gotJump.pcNew));
                    checkOutput("jump_sp_new", 32'(sp_new), 32'(gotJump.spNew));
                    checkOutput("jump_intack", 32'(intack), 32'(gotJump.ack));
                end
            end
            if (intack) begin
                checkOutput("intack_with_load", 32'(pc_load), 32'd1);
            end
            prevWaiting = bus_store && !bus_ack;
            prevAddr    = bus_addr;
            prevData    = bus_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d1;
        int d2;
        logic [15:0] rSp;

        tick();
        tick();
        checkOutput("reset_bus_store", 32'(bus_store), 32'd0);
        checkOutput("reset_loads", 32'({pc_load, sp_load, intack}), 32'd0);
        checkOutput("reset_flags", 32'({ime, halted, cpu_hold}), 32'd0);
        checkOutput("reset_bus_addr", 32'(bus_addr), 32'h0000);
        checkOutput("reset_bus_wdata", 32'(bus_wdata), 32'h00);
        checkOutput("reset_pc_sp_new", {pc_new, sp_new}, 32'h0000_0000);
        reset = 1'b0;
        tick();

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("reti_sets_ime", 32'(ime), 32'd1);
        runDispatch(16'h1234, 16'hFFFE, 16'h0050, 0, 0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runDispatch(16'h1234, 16'hFFFE, 16'h0050, 3, 3, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runDispatch(16'hBEEF, 16'h8000, 16'h0048, 1, 0, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ei_not_immediate", 32'(ime), 32'd0);
        intreq = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ei_boundary_sets_ime", 32'(ime), 32'd1);
        checkOutput("ei_boundary_no_dispatch", 32'(cpu_hold), 32'd0);
        runDispatch(16'h4321, 16'hC000, 16'h0058, 0, 1, 1'b0, 1'b0);

        intreq = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ei_di_same_cycle_ime", 32'(ime), 32'd0);
        checkOutput("ei_di_no_dispatch", 32'(cpu_hold), 32'd0);
        intreq = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("di_beats_reti", 32'(ime), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("halt_sets_halted", 32'({halted, cpu_hold}), 32'b11);
        tick();
        checkOutput("halt_holds", 32'(halted), 32'd1);
        intreq = 1'b1;
        tick();
        intreq = 1'b0;
        checkOutput("halt_wake_no_ime", 32'({halted, cpu_hold}), 32'b00);
        tick();
        tick();
        checkOutput("halt_wake_no_bus", 32'(bus_store), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("halt_with_ime", 32'(halted), 32'd1);
        runDispatch(16'h0777, 16'hD000, 16'h0040, 0, 0, 1'b0, 1'b1);
        checkOutput("halt_cleared_by_dispatch", 32'(halted), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runDispatch(16'hA5C3, 16'h0001, 16'h0060, 0, 2, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pc             = 16'h5555;
        sp             = 16'h2000;
        intaddress     = 16'h0050;
        intreq         = 1'b1;
        instr_boundary = 1'b1;
        bus_ack        = 1'b0;
        tick();
        instr_boundary = 1'b0;
        for (int c = 0; c < 10 && !bus_store; c++) tick();
        checkOutput("reached_push_hi", 32'(bus_store), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("midreset_bus_store", 32'(bus_store), 32'd0);
        checkOutput("midreset_ime_hold", 32'({ime, cpu_hold}), 32'b00);
        checkOutput("midreset_strobes", 32'({intack, pc_load, sp_load}), 32'd0);
        reset  = 1'b0;
        intreq = 1'b0;
        tick();
        tick();

        for (int n = 0; n < 20; n++) begin
            d1 = int'($urandom_range(0, 3));
            d2 = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rSp = 16'h0000;
                1:       rSp = 16'h0001;
                default: rSp = 16'($urandom);
            endcase
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            runDispatch(16'($urandom), rSp, 16'($urandom), d1, d2,
                        ($urandom_range(0, 3) == 0), 1'b0);
        end

        tick();
        checkOutput("writes_drained", expWrites.size(), 32'd0);
        checkOutput("jumps_drained", expJumps.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/int_dispatch.md
INT_DISPATCH -- requirements
Module: int_dispatch

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of idle cycles between dispatch entry and the first stack push (range 0..3).
REQ-002 The block SHALL have port clockgb, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-004 The block SHALL have port intreq, input, 1 bit: a pending, enabled interrupt exists (from the interrupt flag/enable controller).
REQ-005 The block SHALL have port intaddress, input, 16 bits: the vector of the highest-priority pending interrupt.
REQ-006 The block SHALL have port intack, output, 1 bit: one-cycle acknowledge that clears the serviced flag in the controller.
REQ-007 The block SHALL have ports instr_boundary (in, 1: CPU is between instructions), ei_exec, di_exec, reti_exec and halt_exec (in, 1 each: one-cycle instruction strobes).
REQ-008 The block SHALL have ports pc (in, 16) and sp (in, 16): the current CPU registers.
REQ-009 The block SHALL have ports bus_addr (out, 16), bus_wdata (out, 8), bus_store (out, 1) and bus_ack (in, 1): a write request held until acknowledged.
REQ-010 The block SHALL have ports pc_new (out, 16), pc_load (out, 1), sp_new (out, 16) and sp_load (out, 1): register update strobes.
REQ-011 The block SHALL have ports cpu_hold (out, 1: CPU stalled), ime (out, 1: master enable) and halted (out, 1).

Function
REQ-012 States SHALL be IDLE, WAIT, PUSH_HI, PUSH_LO and JUMP.
REQ-013 In IDLE, when instr_boundary=1, ime=1, intreq=1 and di_exec=0, the block SHALL latch pc and sp, clear ime and enter WAIT (or PUSH_HI if WAIT_CYCLES=0).
REQ-014 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 2-bit counter.
REQ-015 In PUSH_HI the block SHALL drive bus_addr=sp_latched-1, bus_wdata=pc_latched[15:8] and bus_store=1, holding these until bus_ack=1, then enter PUSH_LO.
REQ-016 In PUSH_LO the block SHALL drive bus_addr=sp_latched-2 and bus_wdata=pc_latched[7:0], with the same handshake, then enter JUMP.
REQ-017 Address arithmetic SHALL wrap modulo 2^16 (for sp=0x0001, the pushes go to 0x0000 and then 0xFFFF).
REQ-018 JUMP SHALL last one cycle and pulse pc_load and sp_load with sp_new=sp_latched-2, then return to IDLE.
REQ-019 In JUMP, if intreq=1, the block SHALL set pc_new=intaddress and pulse intack; if intreq=0 (request cancelled during the pushes), it SHALL set pc_new=0x0000 and SHALL NOT pulse intack.
REQ-020 cpu_hold SHALL be 1 in every non-IDLE state and while halted=1.
REQ-021 bus_store, pc_load, sp_load and intack SHALL be 0 outside their stated states.
REQ-022 On ei_exec the block SHALL set an internal ei_delay flag; at the next instr_boundary after the cycle of ei_exec, ei_delay SHALL clear and ime SHALL become 1.
REQ-023 The boundary at which ime becomes 1 via ei_delay SHALL NOT start a dispatch, which gives the one-instruction EI delay.
REQ-024 di_exec SHALL clear ime and ei_delay in the next cycle and SHALL take priority over ei_exec, reti_exec and ei_delay in the same cycle.
REQ-025 reti_exec SHALL set ime=1 in the next cycle with no delay.
REQ-026 halt_exec SHALL set halted=1; halted SHALL clear in the first cycle in which intreq=1, regardless of ime.
REQ-027 If halted clears with ime=1, dispatch SHALL start in that same cycle; if ime=0, the CPU SHALL resume with no dispatch.
REQ-028 instr_boundary and strobes arriving while the state is not IDLE SHALL be ignored, except di_exec.
REQ-029 The HALT-bug behaviour is out of scope.

Reset
REQ-030 While reset=1, the block SHALL force state=IDLE, ime=0, ei_delay=0, halted=0, the wait counter to 0 and all strobes to 0, with bus_addr, bus_wdata, pc_new and sp_new at 0x0000/0x00.
REQ-031 Reset asserted mid-dispatch SHALL drop bus_store in the next cycle and SHALL NOT produce intack, pc_load or sp_load.

Verification
REQ-032 Bench: ime=1, pc=0x1234, sp=0xFFFE, intreq=1 with intaddress=0x0050, bus_ack always 1 -> writes 0x12 to 0xFFFD then 0x34 to 0xFFFC; in JUMP, pc_new=0x0050, sp_new=0xFFFC, intack for one cycle; 5 non-IDLE cycles; ime=0.
REQ-033 Bench: as in REQ-032 but bus_ack delayed 3 cycles per push -> bus_addr and bus_wdata stable throughout each delay; total of 11 non-IDLE cycles.
REQ-034 Bench: drop intreq during PUSH_LO -> pc_new=0x0000, no intack, sp_new still equals sp-2.
REQ-035 Bench: ei_exec, then boundary with intreq=1 -> no dispatch and ime becomes 1; the next boundary dispatches. Also ei_exec and di_exec in the same cycle -> ime stays 0.
REQ-036 Bench: halt_exec with ime=0, then intreq=1 -> halted=0 and cpu_hold=0 the next cycle with no bus activity. Repeat with ime=1 -> dispatch starts.
REQ-037 Bench: sp=0x0001 -> pushes go to 0x0000 and 0xFFFF, sp_new=0xFFFF. Also reset asserted in PUSH_HI -> IDLE, bus_store=0, ime=0.
